mem_initiator: RTL and testbench
================================

Name: mem_initiator

Overview:
- Bus master that sits between the CPU datapath (PC/MAR/MBR/IR logic) and the 16Ki x 16 main memory.
- Main memory: synchronous write; registered read, one-cycle latency; data_out holds while write_enable=0 and the address is stable.
- Accepts single-beat write and burst-read requests over a valid/ready handshake.
- Sequences the memory's addr / data_in / write_enable pins and returns read data or write acknowledgements with backpressure.
- Flags out-of-range addresses without touching memory.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MEM_DEPTH, 16384, number of implemented words; addresses >= MEM_DEPTH are out of range.
- LEN_W, 4, burst length field width; a burst is req_len+1 beats (1..16).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_write  in  1  1 = write (single beat), 0 = burst read.
- req_addr  in  ADDR_W  start address.
- req_wdata  in  DATA_W  write data.
- req_len  in  LEN_W  read beats minus one; ignored for writes.
- rsp_valid  out  1  response beat present.
- rsp_ready  in  1  response beat consumed when rsp_valid & rsp_ready.
- rsp_data  out  DATA_W  read data; 0 for writes and error beats.
- rsp_err  out  1  beat address was out of range.
- rsp_last  out  1  final beat of the request.
- mem_addr  out  ADDR_W  to memory addr.
- mem_data_in  out  DATA_W  to memory data_in.
- mem_write_enable  out  1  to memory write_enable.
- mem_data_out  in  DATA_W  from memory data_out.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state=IDLE; mem_addr=0, mem_data_in=0, mem_write_enable=0; rsp_valid=0, rsp_data=0, rsp_err=0, rsp_last=0; internal address and beat counters = 0.
- req_ready = (state==IDLE). It is 0 while reset_n=0.
- States:
  - IDLE: on a request handshake, latch addr, wdata, len and write.
    - Write -> WR.
    - Read -> RD_ADDR.
  - WR (exactly 1 cycle):
    - In range: mem_write_enable=1, mem_addr=addr, mem_data_in=wdata.
    - Out of range: mem_write_enable stays 0.
    - Then -> RESP with rsp_data=0, rsp_err=(addr>=MEM_DEPTH), rsp_last=1.
  - RD_ADDR (1 cycle): mem_addr=addr, mem_write_enable=0 -> RD_DATA.
  - RD_DATA:
    - rsp_valid=1; rsp_data=mem_data_out (0 if out of range); rsp_err=out-of-range; rsp_last=(beat==len).
    - mem_addr is held, so the data is stable under backpressure.
    - On handshake: if last -> IDLE; else addr+1, beat+1 -> RD_ADDR.
  - RESP: rsp_valid=1 until handshake -> IDLE.
- Latency:
  - Write: acknowledgement rsp_valid 2 cycles after the accept edge. Memory is written on the edge ending WR.
  - Read: first rsp_valid 2 cycles after accept; steady state 2 cycles per beat with rsp_ready=1.
- mem_write_enable is 1 only in WR and only for in-range addresses. It is never asserted for more than one cycle per request.
- Address increment wraps 16'hFFFF -> 0. Beats crossing MEM_DEPTH are individually flagged rsp_err=1 with rsp_data=0. The burst still completes all beats.
- rsp_valid, once raised, does not drop and its payload does not change until the handshake.
- A new request is never accepted while a response is pending; there is no overlap.
- Reset asserted mid-operation: immediate return to the reset values. A pending write not yet in WR is never issued. Any partial burst is discarded.

Optional Feature:
- MEM_INITIATOR_STATS_EN
- Defined:
  - Adds outputs rd_beats and wr_count, each 16-bit. Both reset to 0.
  - rd_beats increments on each read response handshake. wr_count increments on each write acknowledgement handshake.
  - Both saturate at 16'hFFFF. Error beats and error writes are counted.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Write addr=0x0010, wdata=0xBEEF -> mem_write_enable high exactly 1 cycle with mem_addr=0x0010 and mem_data_in=0xBEEF; then rsp_valid, rsp_err=0, rsp_last=1.
- Write 0x0010=0xBEEF and 0x0011=0x1234, then read addr=0x0010, len=1 -> two beats: 0xBEEF (last=0), then 0x1234 (last=1).
- Read addr=0x0010, len=0, with rsp_ready held 0 for 5 cycles -> rsp_valid stays 1, rsp_data stays 0xBEEF, req_ready stays 0; accepted when rsp_ready=1.
- Write addr=0x4000 -> mem_write_enable never asserted; rsp_err=1. Read addr=0x3FFF, len=1 -> beat 0: err=0 with valid data; beat 1 (0x4000): err=1, data=0.
- Read addr=0xFFFF, len=1 -> beat 0 err=1; beat 1 mem_addr=0x0000, err=0.
- reset_n low during RD_DATA of a 4-beat burst -> all outputs at reset values immediately; after release, req_ready=1 and no residual rsp_valid.

Source files
------------

// File: rtl/mem_initiator.sv
// mem_initiator: bus master between the CPU datapath and a 16Ki x 16 main
// memory with one-cycle registered read. Accepts single-beat writes and
// burst reads over valid/ready and returns one response beat per write or
// per read word, with backpressure. Out-of-range addresses are flagged
// without touching memory.
// Optional build macro: MEM_INITIATOR_STATS_EN adds rd_beats / wr_count
// saturating handshake counters.
module mem_initiator #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 16384,
  parameter int LEN_W     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rsp_last,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_data_out
`ifdef MEM_INITIATOR_STATS_EN
  ,
  output logic [15:0]       rd_beats,
  output logic [15:0]       wr_count
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_RD_ADDR = 3'd2;
  localparam logic [2:0] S_RD_DATA = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
  logic              mem_we_q, mem_we_d;

  logic req_oor, cur_oor, rsp_state;

  assign req_oor   = {1'b0, req_addr} >= DEPTH_L;
  assign cur_oor   = {1'b0, addr_q} >= DEPTH_L;
  assign rsp_state = (state_q == S_RD_DATA) || (state_q == S_RESP);

  // Handshake and response payload decoded from state; payload is stable
  // under backpressure because addr_q and mem_addr_q hold in RD_DATA/RESP.
  assign req_ready        = (state_q == S_IDLE) && reset_n;
  assign rsp_valid        = rsp_state;
  assign rsp_err          = rsp_state && cur_oor;
  assign rsp_last         = (state_q == S_RESP) ||
                            ((state_q == S_RD_DATA) && (beat_q == len_q));
  assign rsp_data         = ((state_q == S_RD_DATA) && !cur_oor) ? mem_data_out : '0;
  assign mem_addr         = mem_addr_q;
  assign mem_data_in      = mem_data_in_q;
  assign mem_write_enable = mem_we_q;

  // Next-state and memory pin sequencing. Memory pins are registered, so the
  // write strobe is set on the accept edge and is live for exactly the WR cycle.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    beat_d        = beat_q;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    mem_we_d      = 1'b0;
    case (state_q)
      S_IDLE: if (req_valid) begin
        addr_d     = req_addr;
        len_d      = req_len;
        beat_d     = '0;
        mem_addr_d = req_addr;
        if (req_write) begin
          mem_data_in_d = req_wdata;
          mem_we_d      = !req_oor;
          state_d       = S_WR;
        end else begin
          state_d = S_RD_ADDR;
        end
      end
      S_WR:      state_d = S_RESP;
      S_RD_ADDR: state_d = S_RD_DATA;
      S_RD_DATA: if (rsp_ready) begin
        if (beat_q == len_q) begin
          state_d = S_IDLE;
        end else begin
          addr_d     = addr_q + ADDR_W'(1);
          mem_addr_d = addr_q + ADDR_W'(1);
          beat_d     = beat_q + LEN_W'(1);
          state_d    = S_RD_ADDR;
        end
      end
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_we_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      mem_we_q      <= mem_we_d;
    end
  end

`ifdef MEM_INITIATOR_STATS_EN
  logic [15:0] rd_beats_q, rd_beats_d;
  logic [15:0] wr_count_q, wr_count_d;

  // Saturating counters of response handshakes, error beats included.
  always_comb begin
    rd_beats_d = rd_beats_q;
    wr_count_d = wr_count_q;
    if (rsp_ready && (state_q == S_RD_DATA) && (rd_beats_q != 16'hFFFF))
      rd_beats_d = rd_beats_q + 16'd1;
    if (rsp_ready && (state_q == S_RESP) && (wr_count_q != 16'hFFFF))
      wr_count_d = wr_count_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_beats_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_beats_q <= rd_beats_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_beats = rd_beats_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: memory environment, transaction-level reference
// model with a per-cycle compare process, directed scenarios with literal
// expectations, and a randomized request/backpressure phase.
module tb_mem_initiator;
  localparam int DEPTH = 16384;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_len = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_last;
  logic [15:0] rsp_data, mem_addr, mem_data_in, mem_data_out = '0;
  logic        mem_write_enable;

  always #5 clk = ~clk;

  mem_initiator dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_last(rsp_last),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out)
  );

  int n_pass = 0, n_chk = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  function automatic logic [15:0] init_val(int a);
    return 16'(a * 37) ^ 16'h5AC3;
  endfunction

  // Memory environment: sync write, registered read (read-before-write).
  logic [15:0] env_mem [int];
  always @(posedge clk) begin
    int a;
    a = int'(mem_addr[13:0]);
    mem_data_out <= env_mem.exists(a) ? env_mem[a] : init_val(a);
    if (mem_write_enable) env_mem[a] = mem_data_in;
  end

  // Reference model: expected beat queue plus latency/occupancy bookkeeping.
  typedef struct packed { logic [15:0] data; logic err; logic last; } beat_t;
  typedef struct packed { logic [15:0] data; logic err; logic last; logic [15:0] maddr; } obs_t;
  beat_t       exp_q[$];
  obs_t        obs_q[$];
  logic [15:0] ref_mem [int];
  bit          busy = 0, we_exp = 0;
  int          wait_c = 0, we_hi_cnt = 0;
  logic [15:0] we_addr = '0, we_data = '0;

  always @(posedge clk or negedge reset_n) begin
    bit    was_busy;
    beat_t b;
    obs_t  o;
    if (!reset_n) begin
      busy = 0; wait_c = 0; we_exp = 0; exp_q.delete();
    end else begin
      was_busy = busy;
      we_exp = 0;
      if (rsp_valid && rsp_ready) begin
        o.data = rsp_data; o.err = rsp_err; o.last = rsp_last; o.maddr = mem_addr;
        obs_q.push_back(o);
      end
      if (busy && wait_c == 0 && rsp_ready) begin
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          if (b.last) busy = 0; else wait_c = 1;
        end else busy = 0;
      end else if (wait_c > 0) wait_c--;
      if (!was_busy && req_valid) begin
        busy = 1; wait_c = 1;
        if (req_write) begin
          b.data = '0; b.err = (int'(req_addr) >= DEPTH); b.last = 1'b1;
          exp_q.push_back(b);
          if (!b.err) begin
            ref_mem[int'(req_addr)] = req_wdata;
            we_exp = 1; we_addr = req_addr; we_data = req_wdata;
          end
        end else begin
          for (int i = 0; i <= int'(req_len); i++) begin
            logic [15:0] a;
            a = 16'(int'(req_addr) + i);
            b.err  = (int'(a) >= DEPTH);
            b.data = b.err ? 16'h0 :
                     (ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(int'(a)));
            b.last = (i == int'(req_len));
            exp_q.push_back(b);
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("req_ready", 32'(req_ready), 32'(!busy));
      chk("mem_we", 32'(mem_write_enable), 32'(we_exp));
      if (we_exp) begin
        chk("mem_addr_wr", 32'(mem_addr), 32'(we_addr));
        chk("mem_data_in", 32'(mem_data_in), 32'(we_data));
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(busy && wait_c == 0));
      if (busy && wait_c == 0 && exp_q.size() > 0) begin
        chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
        chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
        chk("rsp_last", 32'(rsp_last), 32'(exp_q[0].last));
      end
      if (mem_write_enable) we_hi_cnt++;
    end
  end

  // Response-side backpressure driver.
  bit rand_ready = 0, ready_force = 1;
  always @(negedge clk) rsp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;

  task automatic do_req(input bit w, input logic [15:0] a, input logic [15:0] d,
                        input logic [3:0] l);
    bit ok;
    ok = 0;
    @(negedge clk);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_len = l;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    #1 req_valid = 0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_obs(string nm, int k, logic [15:0] d, logic e, logic l);
    if (obs_q.size() <= k) chk({nm, "_missing"}, 32'(obs_q.size()), 32'(k + 1));
    else begin
      chk({nm, "_data"}, 32'(obs_q[k].data), 32'(d));
      chk({nm, "_err"}, 32'(obs_q[k].err), 32'(e));
      chk({nm, "_last"}, 32'(obs_q[k].last), 32'(l));
    end
  endtask

  task automatic chk_reset_vals(string nm);
    chk({nm, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({nm, "_rsp_data"}, 32'(rsp_data), 32'd0);
    chk({nm, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({nm, "_rsp_last"}, 32'(rsp_last), 32'd0);
    chk({nm, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({nm, "_mem_data_in"}, 32'(mem_data_in), 32'd0);
    chk({nm, "_mem_we"}, 32'(mem_write_enable), 32'd0);
  endtask

  initial begin
    int k, n0;
    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    #1 reset_n = 1;

    // Single in-range write
    n0 = we_hi_cnt; k = obs_q.size();
    do_req(1, 16'h0010, 16'hBEEF, 0);
    @(negedge clk);
    chk("wr_we", 32'(mem_write_enable), 32'd1);
    chk("wr_addr", 32'(mem_addr), 32'h0010);
    chk("wr_wdata", 32'(mem_data_in), 32'hBEEF);
    wait_idle();
    chk("wr_we_cycles", 32'(we_hi_cnt - n0), 32'd1);
    chk_obs("wr_ack", k, 16'h0, 1'b0, 1'b1);

    // Two-beat read-back
    do_req(1, 16'h0011, 16'h1234, 0);
    wait_idle();
    k = obs_q.size();
    do_req(0, 16'h0010, 16'h0, 1);
    wait_idle();
    chk_obs("rd_b0", k, 16'hBEEF, 1'b0, 1'b0);
    chk_obs("rd_b1", k + 1, 16'h1234, 1'b0, 1'b1);

    // Backpressure holds payload and blocks new requests
    ready_force = 0;
    k = obs_q.size();
    do_req(0, 16'h0010, 16'h0, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'hBEEF);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    ready_force = 1;
    wait_idle();
    chk_obs("bp_beat", k, 16'hBEEF, 1'b0, 1'b1);

    // Out-of-range write and a burst crossing MEM_DEPTH
    n0 = we_hi_cnt; k = obs_q.size();
    do_req(1, 16'h4000, 16'hDEAD, 0);
    wait_idle();
    chk("oor_we_cycles", 32'(we_hi_cnt - n0), 32'd0);
    chk_obs("oor_wr", k, 16'h0, 1'b1, 1'b1);
    do_req(1, 16'h3FFF, 16'h5A5A, 0);
    wait_idle();
    k = obs_q.size();
    do_req(0, 16'h3FFF, 16'h0, 1);
    wait_idle();
    chk_obs("edge_b0", k, 16'h5A5A, 1'b0, 1'b0);
    chk_obs("edge_b1", k + 1, 16'h0, 1'b1, 1'b1);

    // Address wrap 0xFFFF -> 0x0000
    k = obs_q.size();
    do_req(0, 16'hFFFF, 16'h0, 1);
    wait_idle();
    if (obs_q.size() < k + 2) chk("wrap_beats", 32'(obs_q.size() - k), 32'd2);
    else begin
      chk("wrap_b0_err", 32'(obs_q[k].err), 32'd1);
      chk("wrap_b0_data", 32'(obs_q[k].data), 32'd0);
      chk("wrap_b1_err", 32'(obs_q[k+1].err), 32'd0);
      chk("wrap_b1_addr", 32'(obs_q[k+1].maddr), 32'h0000);
      chk("wrap_b1_last", 32'(obs_q[k+1].last), 32'd1);
    end

    // Randomized traffic with random backpressure
    rand_ready = 1;
    for (int t = 0; t < 300; t++) begin
      logic [15:0] a;
      case ($urandom_range(0, 3))
        0:       a = 16'($urandom);
        1:       a = 16'(16'h3FF0 + $urandom_range(0, 31));
        2:       a = 16'(16'hFFF0 + $urandom_range(0, 15));
        default: a = 16'($urandom_range(0, 63));
      endcase
      do_req(1'($urandom_range(0, 1)), a, 16'($urandom), 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    rand_ready = 0; ready_force = 0;

    // Reset in the middle of a 4-beat burst
    do_req(0, 16'h0020, 16'h0, 3);
    @(negedge clk); @(negedge clk);
    chk("mid_valid_before", 32'(rsp_valid), 32'd1);
    #2 reset_n = 0;
    #1 chk_reset_vals("midrst");
    @(negedge clk); #1 reset_n = 1;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    ready_force = 1;
    do_req(1, 16'h0010, 16'hCAFE, 0);
    wait_idle();
    k = obs_q.size();
    do_req(0, 16'h0010, 16'h0, 0);
    wait_idle();
    chk_obs("post_rst_rd", k, 16'hCAFE, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
